// File: rtl/fir_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_disp_pkg
// Description : Shared definitions for the FIR peak display stage.
//               - state_t  : peak-tracker FSM state encoding
//               - SEG_0..F : active-low 7-segment patterns {g,f,e,d,c,b,a}
//               - DATA_W_DEF : default filtered-sample width
// Revision    : 1.0 - initial release
// ============================================================================
package fir_disp_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        LATCH = 2'd2
    } state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

endpackage
`default_nettype wire

// File: rtl/hex7seg.sv
`default_nettype none
// ============================================================================
// Module      : hex7seg
// Description : 4-bit nibble to active-low 7-segment decoder (0-F).
// Ports       : i_nibble [3:0] - value to show
//               o_seg    [6:0] - segments {g,f,e,d,c,b,a}, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module hex7seg
    import fir_disp_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_0;
        case (i_nibble)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fir_peak_display.sv
`default_nettype none
// ============================================================================
// Module      : fir_peak_display
// Description : Tracks the peak magnitude of the FIR output over windows of
//               WINDOW valid samples, shows an 8-bit slice of each window's
//               peak on two hex digits and pulses LEDG for LED_CYCLES cycles
//               after every display update.
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous reset, active-low
//               enable     - block enable; low discards a partial window
//               data_in    - signed filtered sample
//               data_valid - data_in qualifier (no backpressure)
//               LEDG       - high while the update indicator timer runs
//               HEX0/HEX1  - low/high nibble digits, active-low segments
// Revision    : 1.0 - initial release
// ============================================================================
module fir_peak_display
    import fir_disp_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int WINDOW     = 1024,
    parameter int DISP_LSB   = 7,
    parameter int LED_CYCLES = 25_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              LEDG,
    output logic [6:0]        HEX0,
    output logic [6:0]        HEX1
);

    localparam int CW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam int LW = $clog2(LED_CYCLES + 1);

    localparam logic [CW-1:0]     c_last     = CW'(WINDOW - 1);
    localparam logic [LW-1:0]     c_led_load = LW'(LED_CYCLES);
    localparam logic [DATA_W-1:0] c_most_neg = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] c_most_pos = {1'b0, {(DATA_W-1){1'b1}}};

    state_t              r_state;
    logic [DATA_W-1:0]   r_peak;
    logic [CW-1:0]       r_count;
    logic [7:0]          r_disp;
    logic [LW-1:0]       r_led_cnt;

    logic [DATA_W-1:0]   w_mag;
    logic [DATA_W-1:0]   w_max;

    // |data_in|; the most negative value has no positive twin, so clamp it.
    always_comb begin
        w_mag = data_in;
        if (data_in[DATA_W-1]) begin
            if (data_in == c_most_neg) begin
                w_mag = c_most_pos;
            end else begin
                w_mag = (~data_in) + DATA_W'(1);
            end
        end
    end

    assign w_max = (w_mag > r_peak) ? w_mag : r_peak;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_peak    <= '0;
            r_count   <= '0;
            r_disp    <= '0;
            r_led_cnt <= '0;
        end else begin
            // Indicator timer runs regardless of enable; a latch restarts it.
            if (r_state == LATCH) begin
                r_led_cnt <= c_led_load;
            end else if (r_led_cnt != '0) begin
                r_led_cnt <= r_led_cnt - LW'(1);
            end

            case (r_state)
                IDLE: begin
                    r_peak  <= '0;
                    r_count <= '0;
                    if (enable) begin
                        r_state <= ACCUM;
                    end
                end

                ACCUM: begin
                    if (!enable) begin
                        r_peak  <= '0;
                        r_count <= '0;
                        r_state <= IDLE;
                    end else if (data_valid) begin
                        // Peak keeps the final sample so LATCH sees the full window.
                        r_peak <= w_max;
                        if (r_count == c_last) begin
                            r_count <= '0;
                            r_state <= LATCH;
                        end else begin
                            r_count <= r_count + CW'(1);
                        end
                    end
                end

                LATCH: begin
                    r_disp <= r_peak[DISP_LSB+7:DISP_LSB];
                    // A sample arriving now is the first of the next window.
                    if (enable && data_valid) begin
                        r_peak  <= w_mag;
                        r_count <= CW'(1);
                    end else begin
                        r_peak  <= '0;
                        r_count <= '0;
                    end
                    r_state <= enable ? ACCUM : IDLE;
                end

                default: begin
                    r_peak  <= '0;
                    r_count <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign LEDG = (r_led_cnt != '0);

    hex7seg u_hex_lo (
        .i_nibble (r_disp[3:0]),
        .o_seg    (HEX0)
    );

    hex7seg u_hex_hi (
        .i_nibble (r_disp[7:4]),
        .o_seg    (HEX1)
    );

endmodule
`default_nettype wire

// File: tb/tb_fir_peak_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_peak_display
// Description : Self-checking bench for fir_peak_display (WINDOW=4,
//               LED_CYCLES=8, DISP_LSB=7). Directed windows from a table,
//               hand sequences for boundary cases, then random traffic
//               compared cycle by cycle against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_peak_display;

    localparam int c_win  = 4;
    localparam int c_led  = 8;
    localparam int c_lsb  = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic        LEDG;
    logic [6:0]  HEX0;
    logic [6:0]  HEX1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fir_peak_display #(
        .DATA_W     (16),
        .WINDOW     (c_win),
        .DISP_LSB   (c_lsb),
        .LED_CYCLES (c_led)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .data_in    (data_in),
        .data_valid (data_valid),
        .LEDG       (LEDG),
        .HEX0       (HEX0),
        .HEX1       (HEX1)
    );

    // Independent segment table, {g,f,e,d,c,b,a} active-low
    logic [6:0] seg_tb [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // ---------------- reference model ----------------
    logic [15:0] m_q [$];      // magnitudes accepted in the current window
    bit          m_armed;      // block was enabled on the previous cycle
    bit          m_pend;       // a window completed; display updates next edge
    int          m_pend_peak;
    logic [7:0]  m_disp;
    int          m_led;

    function automatic logic [15:0] model_mag(input logic [15:0] d);
        int s;
        s = int'($signed(d));
        if (s < 0) s = -s;
        if (s > 32767) s = 32767;
        return 16'(s);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_armed = 0;
        m_pend  = 0;
        m_pend_peak = 0;
        m_disp  = 8'h00;
        m_led   = 0;
    endtask

    task automatic model_edge(input logic r, input logic e, input logic v,
                              input logic [15:0] d);
        int pk;
        if (!r) begin
            model_reset();
            return;
        end
        if (m_pend) begin
            m_disp = 8'((m_pend_peak >> c_lsb) & 255);
            m_led  = c_led;
            m_pend = 0;
        end else if (m_led > 0) begin
            m_led--;
        end
        if (e && v && m_armed) begin
            m_q.push_back(model_mag(d));
            if (m_q.size() == c_win) begin
                pk = 0;
                foreach (m_q[k]) if (int'(m_q[k]) > pk) pk = int'(m_q[k]);
                m_pend = 1;
                m_pend_peak = pk;
                m_q.delete();
            end
        end
        if (!e) m_q.delete();
        m_armed = e;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [14:0] act,
                       input logic [14:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {HEX1,HEX0,LEDG}=%b expected %b at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_model(input string name);
        logic [7:0] dd;
        dd = m_disp;
        chk(name, {HEX1, HEX0, LEDG},
            {seg_tb[dd[7:4]], seg_tb[dd[3:0]], (m_led > 0)});
    endtask

    task automatic chk_hex(input string name, input logic [7:0] d,
                           input logic led);
        chk(name, {HEX1, HEX0, LEDG}, {seg_tb[d[7:4]], seg_tb[d[3:0]], led});
    endtask

    // One clock: drive inputs, advance DUT and model, compare.
    task automatic step(input logic r, input logic e, input logic v,
                        input logic [15:0] d);
        rst = r; enable = e; data_valid = v; data_in = d;
        if (!r) begin
            #1;
            model_reset();
            chk_model("async_reset");
        end
        @(posedge clk);
        #1;
        model_edge(r, e, v, d);
        chk_model("model");
    endtask

    // Idle cycles after a window ends; first cycle must show the new value.
    task automatic led_run(input string name, input logic [7:0] d,
                           output int hi);
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 0, 16'h0);
            if (i == 0) chk_hex(name, d, 1'b1);
            if (LEDG) hi++;
        end
    endtask

    typedef struct {
        logic [15:0] s [4];
        logic [7:0]  disp;
    } win_t;

    win_t tbl [6];
    int   hi;

    initial begin
        tbl[0].s = '{16'h0010, 16'h1234, 16'hFF00, 16'h0800}; tbl[0].disp = 8'h24;
        tbl[1].s = '{16'h8000, 16'h0001, 16'h0002, 16'h0003}; tbl[1].disp = 8'hFF;
        tbl[2].s = '{16'h0080, 16'h0000, 16'h0000, 16'h0000}; tbl[2].disp = 8'h01;
        tbl[3].s = '{16'h0100, 16'hC000, 16'h3F80, 16'h0000}; tbl[3].disp = 8'h80;
        tbl[4].s = '{16'h0000, 16'h0000, 16'h0000, 16'h0000}; tbl[4].disp = 8'h00;
        tbl[5].s = '{16'h0005, 16'h8001, 16'h0100, 16'h7000}; tbl[5].disp = 8'hFF;

        model_reset();

        // Reset and post-release hold
        step(0, 0, 0, 16'h0);
        chk_hex("reset_state", 8'h00, 1'b0);
        step(0, 1, 1, 16'h7FFF);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 16'h7FFF);
        chk_hex("hold_after_release", 8'h00, 1'b0);

        // Basic window with LED duration
        step(1, 1, 0, 16'h0);                  // IDLE -> ACCUM
        step(1, 1, 1, 16'h0010);
        step(1, 1, 1, 16'h1234);
        step(1, 1, 1, 16'hFF00);
        step(1, 1, 1, 16'h0800);
        chk_hex("basic_before_update", 8'h00, 1'b0);
        led_run("basic_update", 8'h24, hi);
        chk_int("basic_led_len", hi, c_led);

        // Table of windows, one idle cycle between windows
        for (int t = 0; t < 6; t++) begin
            for (int j = 0; j < 4; j++) step(1, 1, 1, tbl[t].s[j]);
            step(1, 1, 0, 16'h0);
            chk_hex($sformatf("table_%0d", t), tbl[t].disp, 1'b1);
        end

        // Back-to-back: 8 continuous samples, 5th lands in the LATCH cycle
        for (int j = 0; j < 8; j++) begin
            step(1, 1, 1, (j == 4) ? 16'h7F80 : 16'h0000);
            if (j == 4) chk_hex("b2b_first_window", 8'h00, 1'b1);
        end
        led_run("b2b_second_window", 8'hFF, hi);
        chk_int("b2b_led_retrigger_len", hi, c_led);

        // Enable drop discards the partial window
        step(1, 1, 1, 16'h4000);
        step(1, 1, 1, 16'h4000);
        step(1, 0, 1, 16'h7FFF);
        chk_hex("enable_low_holds_disp", 8'hFF, 1'b0);
        step(1, 1, 1, 16'h7000);               // IDLE cycle: sample ignored
        for (int j = 0; j < 4; j++) step(1, 1, 1, 16'h0100);
        step(1, 1, 0, 16'h0);
        chk_hex("enable_drop_result", 8'h02, 1'b1);

        // Gapped valid stream
        for (int j = 0; j < 7; j++) begin
            step(1, 1, (j % 2) == 0, 16'h0400);
            if (j == 5) chk_hex("gap_no_early_update", 8'h02, 1'b1);
        end
        step(1, 1, 0, 16'h0);
        chk_hex("gap_update", 8'h08, 1'b1);

        // Reset mid-window
        for (int j = 0; j < 3; j++) step(1, 1, 1, 16'h7FFF);
        step(0, 1, 1, 16'h7FFF);
        chk_hex("mid_reset", 8'h00, 1'b0);
        step(1, 1, 0, 16'h0);
        for (int j = 0; j < 3; j++) step(1, 1, 1, 16'h0080);
        step(1, 1, 0, 16'h0);
        chk_hex("post_reset_no_update", 8'h00, 1'b0);
        step(1, 1, 1, 16'h0080);
        step(1, 1, 0, 16'h0);
        chk_hex("post_reset_update", 8'h01, 1'b1);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            logic        r, e, v;
            logic [15:0] d;
            r = ($urandom_range(0, 199) != 0);
            e = ($urandom_range(0, 19) != 0);
            v = ($urandom_range(0, 2) != 0);
            d = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            step(r, e, v, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_peak_display.md
# fir_peak_display

Downstream display stage for the FIR filter output on the FPGA top level. It accepts signed 16-bit filtered samples qualified by a valid strobe and tracks the peak magnitude over a window of WINDOW samples. At each window end it latches that peak, shows an 8-bit slice of it as two hex digits on HEX1/HEX0, and lights LEDG for a fixed time as a "new value" indicator.

## Interface
- DATA_W, 16: sample width, signed two's complement
- WINDOW, 1024: samples per peak window (≥2)
- DISP_LSB, 7: LSB of the 8-bit magnitude slice shown on the display (slice = peak[DISP_LSB+7:DISP_LSB])
- LED_CYCLES, 25_000_000: clock cycles LEDG stays lit after a display update (≥1)
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- enable  in  1  block enable (shared with counter/filter enable)
- data_in  in  DATA_W  filtered sample from firFilter
- data_valid  in  1  data_in valid this cycle; no backpressure, block is always ready
- LEDG  out  1  high while update indicator timer is nonzero
- HEX0  out  7  low-nibble digit, active-low segments {g,f,e,d,c,b,a}
- HEX1  out  7  high-nibble digit, same encoding

## Operation
- Reset (rst=0, async): state IDLE, peak=0, count=0, disp=0x00, led_cnt=0 → HEX1=HEX0=7'b1000000 ("0"), LEDG=0.
- Magnitude: mag = |data_in|, DATA_W-bit unsigned; most negative input saturates to 2^(DATA_W-1)-1 (0x8000 → 0x7FFF).
- FSM states:
  - IDLE: peak, count held at 0. enable=1 → ACCUM.
  - ACCUM: on data_valid: peak ← max(peak, mag), count ← count+1. Sample with count==WINDOW-1 → LATCH (count wraps to 0). enable=0 → IDLE.
  - LATCH (one cycle): disp ← peak slice, led_cnt ← LED_CYCLES, peak ← 0, count ← 0; but a data_valid sample in this cycle seeds the next window: peak ← mag, count ← 1. Next state ACCUM, or IDLE if enable=0 (the latch still happens).
- enable=0 in ACCUM: partial window discarded (peak, count cleared); disp and LEDG timer keep running/holding.
- data_valid ignored in IDLE and whenever enable=0.
- LED timer: decrements by 1 per cycle while nonzero, independent of enable; reload on LATCH even if nonzero (re-triggers full LED_CYCLES).
- HEX decoding: combinational from disp register, digits 0–F standard active-low encoding (0=1000000, 2=0100100, 4=0011001, F=0001110).

## Timing
- Final sample of window accepted at edge E0; LATCH during the following cycle; disp, HEX and LEDG update at edge E1 (one cycle after the final sample).
- LEDG high for exactly LED_CYCLES cycles after E1 absent new latches.
- No combinational path from data_in/data_valid to any output.
- Throughput: one sample per cycle, including the LATCH cycle; no sample is lost at window boundaries.
- Reset asserted mid-window or mid-LED-timer: all state returns to reset values immediately; first window after reset release starts at count 0.

## Structure
- Shared package fir_disp_pkg: FSM state encoding (IDLE, ACCUM, LATCH), 7-segment digit constants (SEG_0…SEG_F, active-low), DATA_W default.
- One sub-module: hex7seg (4-bit nibble → 7-bit active-low segments), instantiated twice.
- Peak/count/FSM, LED timer and display register live in fir_peak_display; the top level connects firFilter output to data_in/data_valid and this block's outputs to LEDG/HEX0/HEX1.

## Test plan
Bench parameters: WINDOW=4, LED_CYCLES=8, DISP_LSB=7.
- Reset: rst=0 at any time → HEX1=HEX0=1000000, LEDG=0; held after release until the first window completes.
- Basic window: enable=1, valid samples 0x0010, 0x1234, -0x0100, 0x0800 on consecutive cycles → one cycle after the 4th sample HEX1=0100100 ("2"), HEX0=0011001 ("4"), LEDG=1 for exactly 8 cycles.
- Saturation: window containing 0x8000 (others small) → displayed 0xFF, HEX1=HEX0=0001110.
- Back-to-back: continuous valid stream of 8 samples, 5th sample = 0x7F80, rest 0 → first window shows 0x00; second window shows 0xFF; LATCH-cycle sample counted into window 2; LEDG re-triggered at the second update and stays high 8 cycles from there.
- Enable drop: 2 valid samples of 0x4000, enable=0 for 1 cycle, enable=1 then 4 samples of 0x0100 → display 0x02 (partial window discarded); display unchanged during enable=0.
- Gaps and mid-op reset: valid toggling every other cycle → update after 4th valid sample only; rst pulse after 3 samples → no update, outputs return to reset values, next update requires 4 fresh samples.
